// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
//
// Free-running VGA raster timing generator. The defaults give the VESA
// 800x600@60 Hz mode from a 40 MHz pixel clock: 1056 pixels per line and
// 628 lines per frame. The module produces pixel/line counters plus
// blanking and sync strobes. Every downstream draw stage keys off these
// outputs.
//
// All outputs are registered. The strobes are decoded from the next-count
// value, so in every cycle they line up with the counter value shown on
// the same cycle.
//
// Ports:
//   clk_i     pixel clock, all logic on the rising edge
//   rst_i     synchronous reset, active high
//   hcount_o  current pixel column, 0..HOR_TOTAL_TIME-1
//   hsync_o   horizontal sync (active level depends on configuration)
//   hblnk_o   1 outside the visible columns
//   vcount_o  current line, 0..VER_TOTAL_TIME-1
//   vsync_o   vertical sync (active level depends on configuration)
//   vblnk_o   1 outside the visible lines
//
// Configuration macro:
//   VGA_SYNC_ACTIVE_LOW_EN  when defined, hsync_o/vsync_o are 0 inside the
//                           sync window and 1 otherwise, and both reset
//                           to 1. When undefined, sync is active high and
//                           both reset to 0.
// ---------------------------------------------------------------------------
module vga_timing #(
  parameter int unsigned HOR_TOTAL_TIME  = 1056,
  parameter int unsigned HOR_BLANK_START = 800,
  parameter int unsigned HOR_SYNC_START  = 840,
  parameter int unsigned HOR_SYNC_TIME   = 128,
  parameter int unsigned VER_TOTAL_TIME  = 628,
  parameter int unsigned VER_BLANK_START = 600,
  parameter int unsigned VER_SYNC_START  = 601,
  parameter int unsigned VER_SYNC_TIME   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [10:0] hcount_o,
  output logic        hsync_o,
  output logic        hblnk_o,
  output logic [10:0] vcount_o,
  output logic        vsync_o,
  output logic        vblnk_o
);

  localparam logic [10:0] H_LAST     = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0] H_BLANK    = 11'(HOR_BLANK_START);
  localparam logic [10:0] H_SYNC_BEG = 11'(HOR_SYNC_START);
  localparam logic [10:0] H_SYNC_END = 11'(HOR_SYNC_START + HOR_SYNC_TIME);
  localparam logic [10:0] V_LAST     = 11'(VER_TOTAL_TIME - 1);
  localparam logic [10:0] V_BLANK    = 11'(VER_BLANK_START);
  localparam logic [10:0] V_SYNC_BEG = 11'(VER_SYNC_START);
  localparam logic [10:0] V_SYNC_END = 11'(VER_SYNC_START + VER_SYNC_TIME);

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic SYNC_ACTIVE = 1'b0;
`else
  localparam logic SYNC_ACTIVE = 1'b1;
`endif

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vsync_q, vsync_d;
  logic        vblnk_q, vblnk_d;

  // Raster counters. The line counter advances only when the pixel counter
  // wraps. Using >= on the wrap test means a counter can never run past
  // its last value, even from an unexpected state.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q >= H_LAST) begin
      hcount_d = '0;
      if (vcount_q >= V_LAST) begin
        vcount_d = '0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end
  end

  // Strobe decode works on the next-count values. The registered strobes
  // then describe the same pixel that the registered counters show.
  always_comb begin
    hblnk_d = (hcount_d >= H_BLANK);
    vblnk_d = (vcount_d >= V_BLANK);
    hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Output registers. Reset parks the raster at the top-left pixel, with
  // blanking clear and both syncs at their inactive level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      hsync_q  <= ~SYNC_ACTIVE;
      vsync_q  <= ~SYNC_ACTIVE;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign hcount_o = hcount_q;
  assign vcount_o = vcount_q;
  assign hsync_o  = hsync_q;
  assign hblnk_o  = hblnk_q;
  assign vsync_o  = vsync_q;
  assign vblnk_o  = vblnk_q;

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
//
// Bench for vga_timing. It instantiates two copies of the design:
//   big   : default 800x600 timing. Used for the line walk, the line wrap
//           and the 1056-clock hsync period.
//   small : shrunk timing (20 x 10). Used to cover whole frames, frame
//           wrap, vblnk/vsync and the frame period in a few hundred clocks.
//
// The big copy is checked against a table of expected values at chosen
// cycles. The small copy is checked every cycle through a scoreboard
// queue, fed from a model that computes its values from the cycle index.
// ---------------------------------------------------------------------------
module tb_vga_timing;

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  localparam logic ACT = 1'b0;
`else
  localparam logic ACT = 1'b1;
`endif

  // Shrunk timing for the small instance.
  localparam int SHT = 20, SHB = 12, SHS = 14, SHW = 3;
  localparam int SVT = 10, SVB = 6,  SVS = 7,  SVW = 2;
  localparam int RUN_CYCLES = 1900;

  logic        clk;
  logic        rst;
  logic [10:0] bH, bV, sH, sV;
  logic        bHs, bHb, bVs, bVb, sHs, sHb, sVs, sVb;

  int checks = 0;
  int passes = 0;

  logic [25:0] sbQ[$];

  typedef struct {
    int          k;
    logic [10:0] h;
    logic [10:0] v;
    logic        hsWin;
    logic        hb;
    logic        vsWin;
    logic        vb;
  } vec_t;

  vec_t vecs[12];

  vga_timing dutBig (
    .clk_i(clk), .rst_i(rst),
    .hcount_o(bH), .hsync_o(bHs), .hblnk_o(bHb),
    .vcount_o(bV), .vsync_o(bVs), .vblnk_o(bVb)
  );

  vga_timing #(
    .HOR_TOTAL_TIME(SHT), .HOR_BLANK_START(SHB), .HOR_SYNC_START(SHS), .HOR_SYNC_TIME(SHW),
    .VER_TOTAL_TIME(SVT), .VER_BLANK_START(SVB), .VER_SYNC_START(SVS), .VER_SYNC_TIME(SVW)
  ) dutSmall (
    .clk_i(clk), .rst_i(rst),
    .hcount_o(sH), .hsync_o(sHs), .hblnk_o(sHb),
    .vcount_o(sV), .vsync_o(sVs), .vblnk_o(sVb)
  );

  // 40 MHz pixel clock
  initial clk = 1'b0;
  always #12.5 clk = ~clk;

  // Expected small-instance outputs k clocks after reset release.
  // The result is packed as {hcount, vcount, hsync, hblnk, vsync, vblnk}.
  function automatic logic [25:0] modelSmall(input int k);
    int   h;
    int   v;
    logic hw;
    logic vw;
    h  = k % SHT;
    v  = (k / SHT) % SVT;
    hw = (h >= SHS) && (h < SHS + SHW);
    vw = (v >= SVS) && (v < SVS + SVW);
    return {11'(h), 11'(v), hw ? ACT : ~ACT, (h >= SHB), vw ? ACT : ~ACT, (v >= SVB)};
  endfunction

  function automatic logic [25:0] packVec(input vec_t e);
    return {e.h, e.v, e.hsWin ? ACT : ~ACT, e.hb, e.vsWin ? ACT : ~ACT, e.vb};
  endfunction

  // Drive reset to the given level, then wait the given number of falling
  // edges so that the caller samples away from the active edge.
  task automatic applyStimulus(input logic r, input int cycles);
    rst = r;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b, expected h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b",
               name, act[25:15], act[14:4], act[3], act[2], act[1], act[0],
               exp[25:15], exp[14:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    logic [25:0] resetVal;
    logic [25:0] exp;
    int          vi;
    logic        bHsPrev, sHsPrev, sVsPrev;
    int          bRise0, bRise1, sRise0, sRise1, sFall0, sFall1;

    // Reset-state expectation: counters at 0, blanking clear, syncs inactive.
    resetVal = {11'd0, 11'd0, ~ACT, 1'b0, ~ACT, 1'b0};

    vecs[0]  = '{k:0,    h:11'd0,    v:11'd0, hsWin:1'b0, hb:1'b0, vsWin:1'b0, vb:1'b0};
    vecs[1]  = '{k:799,  h:11'd799,  v:11'd0, hsWin:1'b0, hb:1'b0, vsWin:1'b0, vb:1'b0};
    vecs[2]  = '{k:800,  h:11'd800,  v:11'd0, hsWin:1'b0, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[3]  = '{k:839,  h:11'd839,  v:11'd0, hsWin:1'b0, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[4]  = '{k:840,  h:11'd840,  v:11'd0, hsWin:1'b1, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[5]  = '{k:967,  h:11'd967,  v:11'd0, hsWin:1'b1, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[6]  = '{k:968,  h:11'd968,  v:11'd0, hsWin:1'b0, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[7]  = '{k:1055, h:11'd1055, v:11'd0, hsWin:1'b0, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[8]  = '{k:1056, h:11'd0,    v:11'd1, hsWin:1'b0, hb:1'b0, vsWin:1'b0, vb:1'b0};
    vecs[9]  = '{k:1057, h:11'd1,    v:11'd1, hsWin:1'b0, hb:1'b0, vsWin:1'b0, vb:1'b0};
    vecs[10] = '{k:1895, h:11'd839,  v:11'd1, hsWin:1'b0, hb:1'b1, vsWin:1'b0, vb:1'b0};
    vecs[11] = '{k:1896, h:11'd840,  v:11'd1, hsWin:1'b1, hb:1'b1, vsWin:1'b0, vb:1'b0};

    $display("[TB] start");

    // Reset held for two clocks.
    applyStimulus(1'b1, 2);
    checkOutput("reset_big",   {bH, bV, bHs, bHb, bVs, bVb}, resetVal);
    checkOutput("reset_small", {sH, sV, sHs, sHb, sVs, sVb}, resetVal);

    // Release reset on this falling edge. k counts rising edges since the release.
    sbQ.push_back(modelSmall(0));
    rst = 1'b0;
    vi = 0;
    bHsPrev = (bHs == ACT); sHsPrev = (sHs == ACT); sVsPrev = (sVs == ACT);
    bRise0 = -1; bRise1 = -1; sRise0 = -1; sRise1 = -1; sFall0 = -1; sFall1 = -1;

    for (int k = 0; k < RUN_CYCLES; k++) begin
      // Scoreboard for the small instance.
      if (sbQ.size() == 0) begin
        checkInt("sb_empty", 0, 1);
      end else begin
        exp = sbQ.pop_front();
        checkOutput($sformatf("sb_small_k%0d", k), {sH, sV, sHs, sHb, sVs, sVb}, exp);
      end

      // Table vectors for the big instance.
      if (vi < 12 && vecs[vi].k == k) begin
        checkOutput($sformatf("vec_big_k%0d", k), {bH, bV, bHs, bHb, bVs, bVb}, packVec(vecs[vi]));
        vi++;
      end

      // Edge tracking for the period checks (in terms of the active level).
      if (!bHsPrev && (bHs == ACT)) begin
        if (bRise0 < 0) bRise0 = k; else if (bRise1 < 0) bRise1 = k;
      end
      if (!sHsPrev && (sHs == ACT)) begin
        if (sRise0 < 0) sRise0 = k; else if (sRise1 < 0) sRise1 = k;
      end
      if (sVsPrev && (sVs != ACT)) begin
        if (sFall0 < 0) sFall0 = k; else if (sFall1 < 0) sFall1 = k;
      end
      bHsPrev = (bHs == ACT); sHsPrev = (sHs == ACT); sVsPrev = (sVs == ACT);

      sbQ.push_back(modelSmall(k + 1));
      @(negedge clk);
    end
    sbQ.delete();

    checkInt("table_vectors_reached", vi, 12);
    checkInt("big_hsync_first_rise", bRise0, 840);
    checkInt("big_hsync_period", (bRise1 < 0) ? -1 : bRise1 - bRise0, 1056);
    checkInt("small_hsync_period", (sRise1 < 0) ? -1 : sRise1 - sRise0, SHT);
    checkInt("small_vsync_fall_period", (sFall1 < 0) ? -1 : sFall1 - sFall0, SHT * SVT);

    // Reset mid-frame: outputs held at the reset state while rst is high.
    applyStimulus(1'b1, 3);
    checkOutput("midreset_hold_big",   {bH, bV, bHs, bHb, bVs, bVb}, resetVal);
    checkOutput("midreset_hold_small", {sH, sV, sHs, sHb, sVs, sVb}, resetVal);
    applyStimulus(1'b1, 1);
    checkOutput("midreset_hold2_small", {sH, sV, sHs, sHb, sVs, sVb}, resetVal);

    // After release, counting restarts from the origin.
    rst = 1'b0;
    checkOutput("restart_k0_small", {sH, sV, sHs, sHb, sVs, sVb}, modelSmall(0));
    applyStimulus(1'b0, 1);
    checkOutput("restart_k1_big",   {bH, bV, bHs, bHb, bVs, bVb}, {11'd1, 11'd0, ~ACT, 1'b0, ~ACT, 1'b0});
    checkOutput("restart_k1_small", {sH, sV, sHs, sHb, sVs, sVb}, modelSmall(1));
    applyStimulus(1'b0, SHT);
    checkOutput("restart_k21_small", {sH, sV, sHs, sHb, sVs, sVb}, modelSmall(SHT + 1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
